time_adjust_ctrl: RTL and testbench
===================================

// Module: time_adjust_ctrl
// PURPOSE
//   Owns the HH:MM:SS BCD time registers of the digital clock. Runs a 1 s prescaler and the carry chain in run mode.
//   In adjust mode it freezes time and applies add/clr pulses from the key controller to the selected digit.
//   Feeds the 7-seg/LCD display path (time_bcd, blink_mask) and the LCD week logic (day_carry).
// PARAMETERS
//   CLK_HZ    50_000_000  clock cycles per second; prescaler terminal count = CLK_HZ-1 (sims use e.g. 10)
//   INIT_BCD  24'h000000  time loaded at reset, {h_hi,h_lo,m_hi,m_lo,s_hi,s_lo}, 4 bits per digit
// PORTS
//   CLOCK_50    in   1   system clock, all logic on posedge
//   rst_n       in   1   asynchronous active-low reset
//   adjust      in   1   1 = run (time advances), 0 = adjust mode
//   select      in   4   digit index: 0=s_lo 1=s_hi 2=m_lo 3=m_hi 4=h_lo 5=h_hi; 6..15 = no digit
//   add         in   1   rising edge = increment selected digit (adjust mode only)
//   clr         in   1   rising edge = zero selected digit (adjust mode only)
//   time_bcd    out  24  {h_hi,h_lo,m_hi,m_lo,s_hi,s_lo}, registered
//   blink_mask  out  6   one-hot selected digit in ADJ, 0 otherwise; bit i = select index i
//   sec_pulse   out  1   1-cycle pulse when time advances one second
//   day_carry   out  1   1-cycle pulse on 23:59:59 -> 00:00:00 rollover
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - time_bcd=INIT_BCD; state=RUN; prescaler=0; add_q=clr_q=0; blink_mask, sec_pulse, day_carry = 0.
//   FSM states: RUN, ADJ, RESYNC.
//   - RUN    : adjust==0 -> ADJ next cycle.
//   - ADJ    : adjust==1 -> RESYNC.
//   - RESYNC : one cycle, then always RUN.
//   RUN:
//   - prescaler counts 0..CLK_HZ-1. At terminal count it wraps to 0 and, in the same cycle, the time increments.
//   - sec_pulse=1 for that cycle.
//   - Carry chain: s_lo 9->0 carries to s_hi; s_hi 5->0 to m_lo; m_lo 9->0 to m_hi; m_hi 5->0 to h_lo.
//   - Hours: h_lo wraps 9->0 (h_hi++) when h_hi<2; 23 -> 00.
//   - day_carry=1 in the same cycle as the rollover, together with sec_pulse.
//   - If adjust falls in a terminal-count cycle, that increment still completes; state goes to ADJ next cycle.
//   ADJ:
//   - Prescaler holds; time frozen; sec_pulse=day_carry=0.
//   - add_q/clr_q register add/clr every cycle in all states.
//   - Edge = add&!add_q (resp. clr&!clr_q), detected in ADJ only. The digit update is visible 1 cycle after the edge cycle.
//   - A level held high (e.g. across reset release) gives no edge until it falls and rises again.
//   - add wraps the selected digit only, with no carry into neighbours: s_lo/m_lo 9->0; s_hi/m_hi 5->0; h_hi 2->0.
//   - h_lo wraps 9->0 if h_hi<2, or 3->0 if h_hi==2.
//   - Any change that leaves h_hi==2 with h_lo>3 forces h_lo=3 in the same update.
//   - clr sets the selected digit to 0. clr and add edges in the same cycle: clr wins, add dropped.
//   - select >= 6: edges ignored, blink_mask=0.
//   - blink_mask=1<<select for select<6; it updates combinationally from a registered state, so it is 0 outside ADJ.
//   RESYNC:
//   - Prescaler cleared to 0, so the first second after adjust is a full CLK_HZ cycles.
//   - No time change and no edges processed.
//   - An add/clr edge arriving in RESYNC is lost.
//   Mid-operation reset: every register returns to its reset value immediately, including inside ADJ.
//   All BCD arithmetic is per 4-bit digit. Digits never leave their legal range, in any mode.
// TESTING (CLK_HZ=10)
//   1 reset, adjust=1, run 10 cycles -> sec_pulse one cycle, time_bcd=24'h000001; 100 cycles -> 24'h000010.
//   2 INIT_BCD=24'h235959, run 10 cycles -> time_bcd=24'h000000 with sec_pulse=day_carry=1 on the same cycle.
//   3 adjust=0, select=4, 4 add edges from 0 -> h_lo=4, blink_mask=6'b010000; 3 cycles later adjust=1 -> RUN after RESYNC.
//     First sec_pulse 10 cycles after the RESYNC cycle.
//   4 ADJ, time 19:00:00, select=5, add -> 29 forced to 23 (24'h230000); add again -> 24'h030000.
//   5 ADJ, add and clr rise on the same cycle, select=0, s_lo=7 -> s_lo=0. select=9 plus add edge -> time unchanged.
//   6 rst_n low for one cycle during ADJ with time 12:34:56 -> time_bcd=INIT_BCD, state RUN, blink_mask=0 at once.
//     add held high through reset gives no increment.

Source files
------------

// File: rtl/time_adjust_ctrl.sv
// time_adjust_ctrl: HH:MM:SS BCD timekeeper with 1 s prescaler, carry chain and per-digit adjust mode
module time_adjust_ctrl #(
  parameter int          CLK_HZ   = 50_000_000,
  parameter logic [23:0] INIT_BCD = 24'h000000
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        adjust,
  input  logic [3:0]  select,
  input  logic        add,
  input  logic        clr,
  output logic [23:0] time_bcd,
  output logic [5:0]  blink_mask,
  output logic        sec_pulse,
  output logic        day_carry
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);
  typedef enum logic [1:0] {RUN, ADJ, RESYNC} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_pre, w_pre;
  logic [5:0][3:0] r_t, w_t;
  logic r_add_q, r_clr_q, r_sec, r_dc;
  logic w_tc, w_sel_ok, w_add_e, w_clr_e, w_c0, w_c1, w_c2, w_c3, w_wrap;
  logic [2:0] w_sel;
  logic [3:0] w_lim;
  assign w_sel    = select[2:0];
  assign w_sel_ok = select < 4'd6;
  assign w_tc     = r_state == RUN && r_pre == TC;
  assign w_add_e  = r_state == ADJ && w_sel_ok && add && !r_add_q;
  assign w_clr_e  = r_state == ADJ && w_sel_ok && clr && !r_clr_q;
  assign w_c0     = r_t[0] == 4'd9;
  assign w_c1     = w_c0 && r_t[1] == 4'd5;
  assign w_c2     = w_c1 && r_t[2] == 4'd9;
  assign w_c3     = w_c2 && r_t[3] == 4'd5;
  assign w_wrap   = r_t[5] == 4'd2 && r_t[4] == 4'd3;
  assign w_lim    = (w_sel == 3'd1 || w_sel == 3'd3) ? 4'd5 :
                    (w_sel == 3'd5) ? 4'd2 :
                    (w_sel == 3'd4 && r_t[5] == 4'd2) ? 4'd3 : 4'd9;
  assign time_bcd   = r_t;
  assign sec_pulse  = r_sec;
  assign day_carry  = r_dc;
  assign blink_mask = (r_state == ADJ && w_sel_ok) ? 6'd1 << w_sel : 6'd0;
  // Mode sequencing and prescaler: counts only in RUN, freezes in ADJ, restarts from 0 on resync
  always_comb begin
    w_next = r_state == RUN ? (adjust ? RUN : ADJ) :
             r_state == ADJ ? (adjust ? RESYNC : ADJ) : RUN;
    w_pre  = (r_state == RESYNC || w_tc) ? '0 : r_state == RUN ? r_pre + 1'b1 : r_pre;
  end
  // Next time value: one-second carry chain in RUN, single-digit clr/add in ADJ, hour clamp always
  always_comb begin
    w_t = r_t;
    if (w_tc) begin
      w_t[0] = w_c0 ? 4'd0 : r_t[0] + 4'd1;
      w_t[1] = w_c1 ? 4'd0 : w_c0 ? r_t[1] + 4'd1 : r_t[1];
      w_t[2] = w_c2 ? 4'd0 : w_c1 ? r_t[2] + 4'd1 : r_t[2];
      w_t[3] = w_c3 ? 4'd0 : w_c2 ? r_t[3] + 4'd1 : r_t[3];
      w_t[4] = w_c3 ? ((w_wrap || r_t[4] == 4'd9) ? 4'd0 : r_t[4] + 4'd1) : r_t[4];
      w_t[5] = (w_c3 && w_wrap) ? 4'd0 : (w_c3 && r_t[4] == 4'd9) ? r_t[5] + 4'd1 : r_t[5];
    end else if (w_clr_e)
      w_t[w_sel] = 4'd0;
    else if (w_add_e)
      w_t[w_sel] = r_t[w_sel] >= w_lim ? 4'd0 : r_t[w_sel] + 4'd1;
    if (w_t[5] == 4'd2 && w_t[4] > 4'd3) w_t[4] = 4'd3;
  end
  // State, prescaler, time digits, key history and registered pulses
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pre   <= '0;
      r_t     <= INIT_BCD;
      r_add_q <= 1'b0;
      r_clr_q <= 1'b0;
      r_sec   <= 1'b0;
      r_dc    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pre   <= w_pre;
      r_t     <= w_t;
      r_add_q <= add;
      r_clr_q <= clr;
      r_sec   <= w_tc;
      r_dc    <= w_tc && w_c3 && w_wrap;
    end
  end
endmodule

// File: tb/tb_time_adjust_ctrl.sv
// tb_time_adjust_ctrl: directed and randomized checks of time_adjust_ctrl against a seconds-based reference model
module tb_time_adjust_ctrl;
  localparam int CLK_HZ = 10;
  logic CLOCK_50 = 0, rst_n = 0, adjust = 1, add = 0, clr = 0;
  logic [3:0] select = 0;
  logic [23:0] t0, t1;
  logic [5:0] b0, b1;
  logic s0, s1, d0, d1;
  int checks = 0, errors = 0;
  int m_mode, m_pre;
  int md[6];
  bit m_aq, m_cq, m_sec, m_dc;

  time_adjust_ctrl #(.CLK_HZ(CLK_HZ), .INIT_BCD(24'h000000)) u0 (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .adjust(adjust), .select(select), .add(add), .clr(clr),
    .time_bcd(t0), .blink_mask(b0), .sec_pulse(s0), .day_carry(d0));
  time_adjust_ctrl #(.CLK_HZ(CLK_HZ), .INIT_BCD(24'h235959)) u1 (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .adjust(adjust), .select(select), .add(add), .clr(clr),
    .time_bcd(t1), .blink_mask(b1), .sec_pulse(s1), .day_carry(d1));

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [23:0] m_bcd();
    return {4'(md[5]), 4'(md[4]), 4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0])};
  endfunction

  function automatic logic [5:0] exp_blink();
    return (m_mode == 1 && select < 6) ? 6'(1 << select) : 6'd0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_aq = 0; m_cq = 0; m_sec = 0; m_dc = 0;
    for (int i = 0; i < 6; i++) md[i] = 0;
  endtask

  task automatic model_step();
    int s, lim;
    bit ae, ce;
    if (!rst_n) return;
    ae = add && !m_aq;
    ce = clr && !m_cq;
    m_sec = 0; m_dc = 0;
    if (m_mode == 0) begin
      if (m_pre == CLK_HZ - 1) begin
        m_pre = 0;
        m_sec = 1;
        s = md[5]*36000 + md[4]*3600 + md[3]*600 + md[2]*60 + md[1]*10 + md[0] + 1;
        if (s == 86400) begin s = 0; m_dc = 1; end
        md[5] = s / 36000; md[4] = (s / 3600) % 10; md[3] = (s % 3600) / 600;
        md[2] = (s / 60) % 10; md[1] = (s % 60) / 10; md[0] = s % 10;
      end else m_pre++;
      if (!adjust) m_mode = 1;
    end else if (m_mode == 1) begin
      if (select < 6) begin
        if (ce) md[select] = 0;
        else if (ae) begin
          lim = (select == 1 || select == 3) ? 5 : (select == 5) ? 2 : (select == 4 && md[5] == 2) ? 3 : 9;
          md[select] = md[select] >= lim ? 0 : md[select] + 1;
        end
        if (md[5] == 2 && md[4] > 3) md[4] = 3;
      end
      if (adjust) m_mode = 2;
    end else begin
      m_pre = 0;
      m_mode = 0;
    end
    m_aq = add;
    m_cq = clr;
  endtask

  task automatic step();
    model_step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(posedge CLOCK_50);
    #1;
    rst_n = 1;
  endtask

  task automatic press(input logic [3:0] sel, input int n);
    select = sel;
    repeat (n) begin
      add = 1; step();
      add = 0; step();
    end
  endtask

  task automatic test_reset();
    adjust = 1; add = 0; clr = 0; select = 0;
    do_reset();
    checks++; if (t0 !== 24'h000000) begin errors++; $display("FAIL reset_time got=%h exp=%h", t0, 24'h000000); end
    checks++; if (t1 !== 24'h235959) begin errors++; $display("FAIL reset_init got=%h exp=%h", t1, 24'h235959); end
    checks++; if (b0 !== 6'd0) begin errors++; $display("FAIL reset_blink got=%b exp=%b", b0, 6'd0); end
    checks++; if ({s0, d0} !== 2'b00) begin errors++; $display("FAIL reset_pulses got=%b exp=00", {s0, d0}); end
  endtask

  task automatic test_run();
    int pulses = 0;
    adjust = 1;
    do_reset();
    repeat (9) begin step(); pulses += s0; end
    checks++; if (pulses != 0 || t0 !== 24'h000000) begin errors++; $display("FAIL run_early pulses=%0d time=%h exp 0/000000", pulses, t0); end
    step();
    checks++; if (s0 !== 1'b1 || t0 !== 24'h000001) begin errors++; $display("FAIL run_1s sec=%b time=%h exp 1/000001", s0, t0); end
    step();
    checks++; if (s0 !== 1'b0) begin errors++; $display("FAIL run_pulse_width sec=%b exp 0", s0); end
    repeat (89) step();
    checks++; if (t0 !== 24'h000010) begin errors++; $display("FAIL run_10s time=%h exp=%h", t0, 24'h000010); end
  endtask

  task automatic test_rollover();
    adjust = 1;
    do_reset();
    repeat (10) step();
    checks++; if (t1 !== 24'h000000) begin errors++; $display("FAIL roll_time got=%h exp=%h", t1, 24'h000000); end
    checks++; if ({s1, d1} !== 2'b11) begin errors++; $display("FAIL roll_pulses got=%b exp=11", {s1, d1}); end
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL roll_no_carry got=%b exp=0", d0); end
    step();
    checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL roll_carry_width got=%b exp=0", d1); end
  endtask

  task automatic test_adjust();
    int n = 0;
    adjust = 1; add = 0; clr = 0;
    do_reset();
    adjust = 0; step();
    press(4, 4);
    checks++; if (t0 !== 24'h040000) begin errors++; $display("FAIL adj_hlo got=%h exp=%h", t0, 24'h040000); end
    checks++; if (b0 !== 6'b010000) begin errors++; $display("FAIL adj_blink got=%b exp=%b", b0, 6'b010000); end
    repeat (3) step();
    adjust = 1; step();
    checks++; if (b0 !== 6'd0) begin errors++; $display("FAIL adj_resync_blink got=%b exp=%b", b0, 6'd0); end
    step();
    for (int i = 1; i <= 20; i++) begin
      step();
      if (s0) begin n = i; break; end
    end
    checks++; if (n != 10) begin errors++; $display("FAIL adj_first_sec cycles=%0d exp=10", n); end
    checks++; if (t0 !== 24'h040001) begin errors++; $display("FAIL adj_after_run got=%h exp=%h", t0, 24'h040001); end
  endtask

  task automatic test_hours();
    adjust = 1; add = 0; clr = 0;
    do_reset();
    adjust = 0; step();
    press(5, 1);
    press(4, 9);
    checks++; if (t0 !== 24'h190000) begin errors++; $display("FAIL hours_19 got=%h exp=%h", t0, 24'h190000); end
    press(5, 1);
    checks++; if (t0 !== 24'h230000) begin errors++; $display("FAIL hours_clamp got=%h exp=%h", t0, 24'h230000); end
    press(5, 1);
    checks++; if (t0 !== 24'h030000) begin errors++; $display("FAIL hours_hhi_wrap got=%h exp=%h", t0, 24'h030000); end
  endtask

  task automatic test_clr();
    adjust = 1; add = 0; clr = 0;
    do_reset();
    adjust = 0; step();
    press(0, 7);
    checks++; if (t0 !== 24'h000007) begin errors++; $display("FAIL clr_setup got=%h exp=%h", t0, 24'h000007); end
    add = 1; clr = 1; step();
    add = 0; clr = 0; step();
    checks++; if (t0 !== 24'h000000) begin errors++; $display("FAIL clr_wins got=%h exp=%h", t0, 24'h000000); end
    press(0, 1);
    press(9, 1);
    checks++; if (t0 !== 24'h000001) begin errors++; $display("FAIL sel_ignored got=%h exp=%h", t0, 24'h000001); end
    checks++; if (b0 !== 6'd0) begin errors++; $display("FAIL sel_blink got=%b exp=%b", b0, 6'd0); end
  endtask

  task automatic test_midreset();
    adjust = 1; add = 0; clr = 0;
    do_reset();
    adjust = 0; step();
    press(5, 1); press(4, 2); press(3, 3); press(2, 4); press(1, 5); press(0, 6);
    checks++; if (t0 !== 24'h123456) begin errors++; $display("FAIL mid_setup got=%h exp=%h", t0, 24'h123456); end
    add = 1;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (t0 !== 24'h000000) begin errors++; $display("FAIL mid_async_time got=%h exp=%h", t0, 24'h000000); end
    checks++; if (b0 !== 6'd0) begin errors++; $display("FAIL mid_async_blink got=%b exp=%b", b0, 6'd0); end
    @(posedge CLOCK_50); #1;
    rst_n = 1;
    repeat (3) step();
    checks++; if (t0 !== 24'h000000) begin errors++; $display("FAIL mid_held_add got=%h exp=%h", t0, 24'h000000); end
    checks++; if (b0 !== 6'b000001) begin errors++; $display("FAIL mid_adj_blink got=%b exp=%b", b0, 6'b000001); end
    add = 0; step();
    add = 1; step();
    checks++; if (t0 !== 24'h000001) begin errors++; $display("FAIL mid_new_edge got=%h exp=%h", t0, 24'h000001); end
    add = 0;
  endtask

  task automatic test_random();
    adjust = 1; add = 0; clr = 0; select = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) adjust = ~adjust;
      select = 4'($urandom_range(0, 7));
      add = $urandom_range(0, 2) == 0;
      clr = $urandom_range(0, 11) == 0;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        model_reset();
        #1;
      end else rst_n = 1;
      step();
      checks++; if (t0 !== m_bcd()) begin errors++; $display("FAIL rnd_time cyc=%0d got=%h exp=%h", c, t0, m_bcd()); end
      checks++; if (b0 !== exp_blink()) begin errors++; $display("FAIL rnd_blink cyc=%0d got=%b exp=%b", c, b0, exp_blink()); end
      checks++; if (s0 !== m_sec) begin errors++; $display("FAIL rnd_sec cyc=%0d got=%b exp=%b", c, s0, m_sec); end
      checks++; if (d0 !== m_dc) begin errors++; $display("FAIL rnd_day cyc=%0d got=%b exp=%b", c, d0, m_dc); end
    end
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_rollover();
    test_adjust();
    test_hours();
    test_clr();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
